seq_checker: RTL and testbench
==============================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter SIZE, default 4, width of sequence position and round length.
REQ-002 Parameter DEB_CYCLES, default 4, consecutive stable cycles needed to accept a button level.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum cycles waiting for a press before error.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 R  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin or restart checking a round.
REQ-007 btn  input  4  raw asynchronous push-buttons, active-high.
REQ-008 exp_code  input  2  expected button code at the current position.
REQ-009 seq_pos  input  SIZE  current user position, supplied by the downstream position counter.
REQ-010 round_len  input  SIZE  last valid position of the round.
REQ-011 E  output  1  one-cycle count-enable pulse per matched press.
REQ-012 user_code  output  2  code of the last accepted press.
REQ-013 round_done  output  1  one-cycle pulse when the last position is matched.
REQ-014 error  output  1  level; mismatch, invalid press or timeout.

Function
REQ-015 btn SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Debounced vector SHALL update only after the synchronized value is unchanged for DEB_CYCLES consecutive cycles.
REQ-017 Button code SHALL be encoded btn[0]=0, btn[1]=1, btn[2]=2, btn[3]=3.
REQ-018 FSM states SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE, CHECK, DONE, ERROR.
REQ-019 IDLE: start=1 -> WAIT_PRESS, timeout counter cleared; otherwise stay.
REQ-020 WAIT_PRESS: debounced vector one-hot -> latch user_code, go WAIT_RELEASE; more than one bit set -> ERROR; timeout counter reaching TIMEOUT_CYCLES-1 -> ERROR.
REQ-021 WAIT_RELEASE: debounced vector all zero -> CHECK; no timeout applies.
REQ-022 CHECK (exactly one cycle): user_code==exp_code and seq_pos==round_len -> DONE; user_code==exp_code otherwise -> WAIT_PRESS with timeout cleared; mismatch -> ERROR.
REQ-023 E SHALL be registered, asserted for exactly the one cycle following a matching CHECK; never asserted on mismatch.
REQ-024 round_done SHALL be asserted for one cycle on entry to DONE, coincident with the final E; DONE returns to IDLE next cycle.
REQ-025 error SHALL assert on entry to ERROR and hold until R or start.
REQ-026 ERROR: start=1 -> WAIT_PRESS, error cleared same edge.
REQ-027 start SHALL be ignored in WAIT_PRESS, WAIT_RELEASE and CHECK.
REQ-028 A press held from before start SHALL NOT be accepted until released and pressed again.

Reset
REQ-029 R=1 at a clock edge SHALL force IDLE, E=0, round_done=0, error=0, user_code=0, synchronizer, debounce and timeout registers cleared, regardless of state.

Structure
REQ-030 State encoding and button-code constants SHALL reside in a shared package.
REQ-031 Synchronizer plus debounce SHALL be a sub-module button_debounce, parameterized by DEB_CYCLES.

Verification (SIZE=4, DEB_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-032 round_len=2; exp_code 1,3,0 at seq_pos 0,1,2; clean presses btn=0010,1000,0001 -> three E pulses, round_done once with third E, error=0.
REQ-033 btn[2] toggling every cycle for 3 cycles then 0 -> no press accepted, E=0, state stays WAIT_PRESS.
REQ-034 exp_code=2, press btn=0010 -> error=1, no E; then start=1 -> error=0, WAIT_PRESS.
REQ-035 btn=0011 held 10 cycles in WAIT_PRESS -> error=1, no E.
REQ-036 start, no press -> error rises on 64th cycle after entering WAIT_PRESS.
REQ-037 R pulsed in WAIT_RELEASE -> all outputs 0 next edge, IDLE; subsequent release produces no E.

Source files
------------

// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the sequence checker: FSM state encoding,
// button-code constants and small helpers for decoding a debounced vector.
package seq_checker_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_PRESS   = 3'd1,
      WAIT_RELEASE = 3'd2,
      CHECK        = 3'd3,
      DONE         = 3'd4,
      ERROR        = 3'd5
   } state_t;

   localparam int BTN_W = 4;

   localparam logic [1:0] CODE_BTN0 = 2'd0;
   localparam logic [1:0] CODE_BTN1 = 2'd1;
   localparam logic [1:0] CODE_BTN2 = 2'd2;
   localparam logic [1:0] CODE_BTN3 = 2'd3;

   // True when exactly one button is pressed.
   function automatic logic is_onehot(input logic [BTN_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Map a one-hot button vector to its code; only meaningful when one-hot.
   function automatic logic [1:0] encode_btn(input logic [BTN_W-1:0] v);
      logic [1:0] code;
      code = CODE_BTN0;
      if (v[1]) code = CODE_BTN1;
      if (v[2]) code = CODE_BTN2;
      if (v[3]) code = CODE_BTN3;
      return code;
   endfunction

endpackage

// File: rtl/seq_checker_button_debounce.sv
// Two-flop synchronizer followed by a vector-wide debouncer: the output only
// takes a new value after the synchronized input has held still for
// DEB_CYCLES consecutive cycles.
module button_debounce #(
   parameter int WIDTH      = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             R,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] deb
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] cand_reg;
   logic [WIDTH-1:0] deb_reg;
   logic [CW-1:0]    cnt_reg;

   // Per-bit two-stage synchronizer for the asynchronous button inputs.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
      always_ff @(posedge clk) begin
         if (R) begin
            sync1_reg[gi] <= 1'b0;
            sync2_reg[gi] <= 1'b0;
         end else begin
            sync1_reg[gi] <= raw[gi];
            sync2_reg[gi] <= sync1_reg[gi];
         end
      end
   end

   // Restart the stability count on any change; commit once it saturates.
   always_ff @(posedge clk) begin
      if (R) begin
         cand_reg <= '0;
         cnt_reg  <= '0;
         deb_reg  <= '0;
      end else if (sync2_reg != cand_reg) begin
         cand_reg <= sync2_reg;
         cnt_reg  <= '0;
      end else if (cnt_reg == CNT_MAX) begin
         deb_reg <= cand_reg;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign deb = deb_reg;

endmodule

// File: rtl/seq_checker.sv
// Checks user button presses against an expected code sequence supplied by
// surrounding logic, pulsing E per matched press and round_done at the end.
module seq_checker
   import seq_checker_pkg::*;
#(
   parameter int SIZE           = 4,
   parameter int DEB_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            R,
   input  logic            start,
   input  logic [3:0]      btn,
   input  logic [1:0]      exp_code,
   input  logic [SIZE-1:0] seq_pos,
   input  logic [SIZE-1:0] round_len,
   output logic            E,
   output logic [1:0]      user_code,
   output logic            round_done,
   output logic            error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]    deb;
   state_t        state_reg, state_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic          armed_reg, armed_next;   // buttons seen released since start
   logic [1:0]    code_reg, code_next;
   logic          e_reg, e_next;
   logic          done_reg, done_next;

   button_debounce #(
      .WIDTH      (4),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk (clk),
      .R   (R),
      .raw (btn),
      .deb (deb)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (R) begin
         state_reg <= IDLE;
         tmo_reg   <= '0;
         armed_reg <= 1'b0;
         code_reg  <= '0;
         e_reg     <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         tmo_reg   <= tmo_next;
         armed_reg <= armed_next;
         code_reg  <= code_next;
         e_reg     <= e_next;
         done_reg  <= done_next;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_next = state_reg;
      tmo_next   = tmo_reg;
      armed_next = armed_reg;
      code_next  = code_reg;
      e_next     = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         IDLE, ERROR: begin
            // A press already held at start must be released before it counts.
            if (start) begin
               state_next = WAIT_PRESS;
               tmo_next   = '0;
               armed_next = 1'b0;
            end
         end
         WAIT_PRESS: begin
            if (armed_reg && (deb != '0)) begin
               if (is_onehot(deb)) begin
                  code_next  = encode_btn(deb);
                  state_next = WAIT_RELEASE;
               end else begin
                  state_next = ERROR;
               end
            end else if (tmo_reg == TMO_MAX) begin
               state_next = ERROR;
            end else begin
               tmo_next = tmo_reg + 1'b1;
               if (deb == '0) armed_next = 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (deb == '0) state_next = CHECK;
         end
         CHECK: begin
            if (code_reg == exp_code) begin
               e_next = 1'b1;
               if (seq_pos == round_len) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  // Buttons are known released here, so re-arm directly.
                  state_next = WAIT_PRESS;
                  tmo_next   = '0;
                  armed_next = 1'b1;
               end
            end else begin
               state_next = ERROR;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign E          = e_reg;
   assign round_done = done_reg;
   assign user_code  = code_reg;
   assign error      = (state_reg == ERROR);

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: table-driven single presses, hand
// sequences for multi-cycle corners, and randomized rounds vs a round model.
module tb_seq_checker;

   logic       clk = 1'b0;
   logic       R = 1'b1;
   logic       start = 1'b0;
   logic [3:0] btn = '0;
   logic [1:0] exp_code = '0;
   logic [3:0] seq_pos = '0;
   logic [3:0] round_len = '0;
   logic       E;
   logic [1:0] user_code;
   logic       round_done;
   logic       error;

   int n_checks = 0;
   int n_fail = 0;
   int e_seen, done_seen, coinc;
   logic [1:0] codes [16];

   seq_checker dut (
      .clk        (clk),
      .R          (R),
      .start      (start),
      .btn        (btn),
      .exp_code   (exp_code),
      .seq_pos    (seq_pos),
      .round_len  (round_len),
      .E          (E),
      .user_code  (user_code),
      .round_done (round_done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] b;
      logic [1:0] ex;
      int         e;
      int         err;
      int         uc;   // -1: do not check
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Advance n clock edges, sampling just after each; models the downstream
   // position counter which advances on every E pulse.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (E) begin
            e_seen++;
            seq_pos = seq_pos + 1'b1;
            exp_code = codes[seq_pos];
         end
         if (round_done) done_seen++;
         if (E && round_done) coinc++;
      end
   endtask

   task automatic clr();
      e_seen = 0;
      done_seen = 0;
      coinc = 0;
   endtask

   task automatic do_reset();
      R = 1'b1;
      btn = '0;
      start = 1'b0;
      tick(2);
      R = 1'b0;
      tick(1);
   endtask

   task automatic do_start(input int len);
      round_len = 4'(len);
      seq_pos = '0;
      exp_code = codes[0];
      start = 1'b1;
      tick(1);
      start = 1'b0;
      clr();
   endtask

   task automatic press(input logic [3:0] v);
      $display("press btn=%b exp_code=%0d seq_pos=%0d", v, exp_code, seq_pos);
      btn = v;
      tick(10);
      btn = '0;
      tick(14);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      int len, exp_e, exp_err, last_c, c;
      logic [3:0] v;

      for (int i = 0; i < 16; i++) codes[i] = '0;
      tbl[0] = '{4'b0001, 2'd0, 1, 0, 0};
      tbl[1] = '{4'b0010, 2'd1, 1, 0, 1};
      tbl[2] = '{4'b0100, 2'd2, 1, 0, 2};
      tbl[3] = '{4'b1000, 2'd3, 1, 0, 3};
      tbl[4] = '{4'b0001, 2'd3, 0, 1, 0};
      tbl[5] = '{4'b0100, 2'd1, 0, 1, 2};
      tbl[6] = '{4'b0011, 2'd0, 0, 1, -1};
      tbl[7] = '{4'b1100, 2'd2, 0, 1, -1};

      // Reset state
      clr();
      do_reset();
      check("reset_E", int'(E), 0);
      check("reset_round_done", int'(round_done), 0);
      check("reset_error", int'(error), 0);
      check("reset_user_code", int'(user_code), 0);

      // Table: single-press rounds of length one
      for (int i = 0; i < 8; i++) begin
         do_reset();
         codes[0] = tbl[i].ex;
         do_start(0);
         press(tbl[i].b);
         $display("table[%0d] btn=%b exp=%0d -> E=%0d done=%0d err=%0d uc=%0d",
                  i, tbl[i].b, tbl[i].ex, e_seen, done_seen, error, user_code);
         check("table_E", e_seen, tbl[i].e);
         check("table_done", done_seen, tbl[i].e);
         check("table_error", int'(error), tbl[i].err);
         if (tbl[i].uc >= 0) check("table_user_code", int'(user_code), tbl[i].uc);
      end

      // Three-step round 1,3,0 with round_len 2
      do_reset();
      codes[0] = 2'd1; codes[1] = 2'd3; codes[2] = 2'd0;
      do_start(2);
      press(4'b0010);
      press(4'b1000);
      press(4'b0001);
      $display("round3 E=%0d done=%0d coinc=%0d err=%0d", e_seen, done_seen, coinc, error);
      check("round3_E", e_seen, 3);
      check("round3_done", done_seen, 1);
      check("round3_done_with_E", coinc, 1);
      check("round3_error", int'(error), 0);

      // Bouncing button: never stable long enough
      do_reset();
      codes[0] = 2'd2;
      do_start(0);
      btn = 4'b0100; tick(1);
      btn = 4'b0000; tick(1);
      btn = 4'b0100; tick(1);
      btn = 4'b0000; tick(20);
      $display("bounce E=%0d err=%0d", e_seen, error);
      check("bounce_E", e_seen, 0);
      check("bounce_error", int'(error), 0);
      press(4'b0100);
      check("bounce_then_press_E", e_seen, 1);

      // Mismatch then restart from error
      do_reset();
      codes[0] = 2'd2;
      do_start(0);
      press(4'b0010);
      check("mismatch_error", int'(error), 1);
      check("mismatch_E", e_seen, 0);
      do_start(0);
      check("restart_clears_error", int'(error), 0);
      press(4'b0100);
      check("restart_press_E", e_seen, 1);

      // Two buttons held together
      do_reset();
      codes[0] = 2'd0;
      do_start(0);
      btn = 4'b0011; tick(10);
      btn = 4'b0000; tick(4);
      $display("double E=%0d err=%0d", e_seen, error);
      check("double_error", int'(error), 1);
      check("double_E", e_seen, 0);

      // Timeout with no press
      do_reset();
      do_start(0);
      first = 0;
      for (int k = 1; k <= 70; k++) begin
         tick(1);
         if (error && first == 0) first = k;
      end
      $display("timeout error at cycle %0d", first);
      check("timeout_cycle", first, 64);
      check("timeout_error_holds", int'(error), 1);

      // Press held from before start must be released first
      do_reset();
      codes[0] = 2'd0;
      btn = 4'b0001; tick(12);
      do_start(0);
      tick(15);
      check("held_press_E", e_seen, 0);
      check("held_press_error", int'(error), 0);
      btn = 4'b0000; tick(12);
      press(4'b0001);
      check("repress_E", e_seen, 1);

      // Reset in WAIT_RELEASE
      do_reset();
      codes[0] = 2'd1;
      do_start(0);
      btn = 4'b0010; tick(12);
      R = 1'b1; tick(1);
      check("rst_mid_E", int'(E), 0);
      check("rst_mid_done", int'(round_done), 0);
      check("rst_mid_error", int'(error), 0);
      check("rst_mid_user_code", int'(user_code), 0);
      R = 1'b0;
      btn = 4'b0000; tick(20);
      check("rst_mid_no_E", e_seen, 0);

      // Randomized rounds against a transaction-level model
      do_reset();
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 3);
         for (int i = 0; i <= len; i++) codes[i] = 2'($urandom_range(0, 3));
         do_start(len);
         exp_e = 0; exp_err = 0; last_c = 0;
         for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 4) == 0)
               c = (int'(codes[i]) + 1 + int'($urandom_range(0, 2))) % 4;
            else
               c = int'(codes[i]);
            v = 4'b0001 << c;
            press(v);
            last_c = c;
            if (c != int'(codes[i])) begin
               exp_err = 1;
               break;
            end
            exp_e++;
         end
         $display("random[%0d] len=%0d E=%0d/%0d done=%0d err=%0d/%0d",
                  r, len, e_seen, exp_e, done_seen, error, exp_err);
         check("rand_E", e_seen, exp_e);
         check("rand_done", done_seen, 1 - exp_err);
         check("rand_error", int'(error), exp_err);
         check("rand_user_code", int'(user_code), last_c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
